// File: rtl/secure_rx_deframer.sv
// Receive deframer: hunts for a sync byte, gathers a 16-byte block plus XOR checksum,
// and hands the key-decrypted block to a one-entry valid/ready output buffer.
module secure_rx_deframer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     key,
  output logic [127:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             crc_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_CSUM    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       csum_q, csum_d;
  logic [127:0]     shift_q, shift_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [127:0]     out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             crc_err_q, crc_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic ready;
  logic accept;
  logic load;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      ST_HUNT:    ready = 1'b1;
      ST_PAYLOAD: ready = 1'b1;
      // The checksum byte may only land when the output buffer can take the block.
      ST_CSUM:    ready = !out_valid_q || out_ready;
      default:    ready = 1'b0;
    endcase
  end

  assign accept   = in_valid && ready;
  assign in_ready = ready && !rst;

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    csum_d        = csum_q;
    shift_d       = shift_q;
    tmo_d         = tmo_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    crc_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;
    load          = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d = ST_PAYLOAD;
          idx_d   = 4'd0;
          csum_d  = 8'd0;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          shift_d = {shift_q[119:0], in_data};
          csum_d  = csum_q ^ in_data;
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) load = 1'b1;
          else                   crc_err_d = 1'b1;
          state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Idle cycles inside a frame age the timer; back-pressured checksum cycles hold it.
    if (state_q == ST_HUNT) begin
      tmo_d = '0;
    end else if (accept) begin
      tmo_d = '0;
    end else if (ready) begin
      if (tmo_q == TMO_LAST) begin
        timeout_err_d = 1'b1;
        state_d       = ST_HUNT;
        tmo_d         = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (load) begin
      out_data_d  = shift_q ^ key;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (load && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    if ((crc_err_d || timeout_err_d) && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  // NOTE: the wide data registers are reset as well, so out_data reads 0 straight after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      idx_q         <= 4'd0;
      csum_q        <= 8'd0;
      shift_q       <= '0;
      tmo_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the same pre-edge values.
      state_q       <= state_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      shift_q       <= shift_d;
      tmo_q         <= tmo_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      crc_err_q     <= crc_err_d;
      timeout_err_q <= timeout_err_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign crc_err     = crc_err_q;
  assign timeout_err = timeout_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_secure_rx_deframer.sv
// Directed bench for secure_rx_deframer: good/bad frames, junk, timeout,
// output back-pressure and mid-frame reset, with hand-computed expectations.
module tb_secure_rx_deframer;

  localparam int TMO = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         crc_err;
  logic         timeout_err;
  logic [15:0]  frame_cnt;
  logic [15:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  secure_rx_deframer #(
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TMO),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key        (key),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .crc_err    (crc_err),
    .timeout_err(timeout_err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [127:0] p);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 16; i++) s = s ^ p[8*i +: 8];
    return s;
  endfunction

  // Presents one byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_wait", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_head(input logic [127:0] p);
    send_byte(8'hA5);
    for (int i = 0; i < 16; i++) send_byte(p[127-8*i -: 8]);
  endtask

  task automatic send_frame(input logic [127:0] p, input logic [7:0] cs);
    send_head(p);
    send_byte(cs);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] p_seq, p3, p4, p6;
    logic         seen_tmo, seen_rdy;
    p_seq = 128'h000102030405060708090A0B0C0D0E0F;
    p3    = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
    p4    = 128'hA50102030405060708090A0B0C0D0EA5;
    p6    = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; key = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_pulses", {crc_err, timeout_err}, 0);
    rst = 1'b0;
    #1;
    check("hunt_in_ready", in_ready, 1);

    // 1: sequential payload, zero key, latency N+1
    key = '0;
    send_head(p_seq);
    check("t1_valid_before_csum", out_valid, 0);
    send_byte(8'h00);
    check("t1_valid_n_plus_1", out_valid, 1);
    check("t1_data", out_data, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_frame_cnt", frame_cnt, 1);
    consume();
    check("t1_valid_cleared", out_valid, 0);

    // 2: all-ones key inverts 0x3C to 0xC3
    key = '1;
    send_frame({16{8'h3C}}, 8'h00);
    check("t2_data", out_data, {16{8'hC3}});
    check("t2_frame_cnt", frame_cnt, 2);
    consume();

    // 3: bad checksum, then a good frame with a 0x0F key
    key = '0;
    send_frame(p_seq, 8'h01);
    check("t3_crc_pulse", crc_err, 1);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_no_valid", out_valid, 0);
    @(posedge clk); #1;
    check("t3_crc_one_cycle", crc_err, 0);
    key = {16{8'h0F}};
    send_frame(p3, xsum(p3));
    check("t3_good_valid", out_valid, 1);
    check("t3_good_data", out_data, 128'hD1A2B1E00E2C4A6886A4C2E0F1D3B597);
    check("t3_frame_cnt", frame_cnt, 3);
    consume();

    // 4: junk before sync is discarded; 0xA5 inside payload is plain data
    key = '0;
    send_byte(8'h11);
    send_byte(8'h22);
    check("t4_junk_hunt", in_ready, 1);
    send_frame(p4, xsum(p4));
    check("t4_data", out_data, 128'hA50102030405060708090A0B0C0D0EA5);
    check("t4_frame_cnt", frame_cnt, 4);
    check("t4_err_cnt", err_cnt, 1);
    consume();

    // 5: stall mid-payload for TIMEOUT_CYC idle cycles
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
    seen_tmo = 1'b0;
    repeat (TMO - 1) begin
      @(posedge clk); #1;
      if (timeout_err) seen_tmo = 1'b1;
    end
    check("t5_no_early_timeout", seen_tmo, 0);
    @(posedge clk); #1;
    check("t5_timeout_pulse", timeout_err, 1);
    check("t5_err_cnt", err_cnt, 2);
    check("t5_no_crc", crc_err, 0);
    @(posedge clk); #1;
    check("t5_timeout_one_cycle", timeout_err, 0);
    send_frame(p_seq, 8'h00);
    check("t5_recover_data", out_data, 128'h000102030405060708090A0B0C0D0E0F);
    check("t5_frame_cnt", frame_cnt, 5);
    consume();

    // 6: back-pressure holds the second checksum byte; key sampled at load
    key = '0;
    send_frame({16{8'h55}}, 8'h00);
    check("t6_first_valid", out_valid, 1);
    send_head(p6);
    check("t6_csum_stalled", in_ready, 0);
    in_data  = xsum(p6);
    in_valid = 1'b1;
    key      = '1;
    seen_tmo = 1'b0;
    seen_rdy = 1'b0;
    repeat (TMO + 200) begin
      @(posedge clk); #1;
      if (timeout_err) seen_tmo = 1'b1;
      if (in_ready) seen_rdy = 1'b1;
    end
    check("t6_no_timeout", seen_tmo, 0);
    check("t6_ready_held_low", seen_rdy, 0);
    check("t6_first_data_held", out_data, {16{8'h55}});
    out_ready = 1'b1;
    #1;
    check("t6_ready_follows", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t6_no_bubble", out_valid, 1);
    check("t6_second_data", out_data, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
    check("t6_frame_cnt", frame_cnt, 7);
    @(posedge clk); #1;
    check("t6_drained", out_valid, 0);
    out_ready = 1'b0;

    // Reset mid-payload with a block still pending
    key = '0;
    send_frame({16{8'h55}}, 8'h00);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_data", out_data, 0);
    check("mrst_counters", {frame_cnt, err_cnt}, 0);
    check("mrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    send_frame(p_seq, 8'h00);
    check("mrst_recover_data", out_data, 128'h000102030405060708090A0B0C0D0E0F);
    check("mrst_recover_cnt", frame_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
